// File: rtl/cbrt_newton_seq.sv
// Integer cube-root sequencer: Newton iteration x' = (2x + N/x^2) / 3, with both
// divisions per step issued to an external registered divider of latency DIV_LAT.
module cbrt_newton_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV_LAT  = 1,
  parameter int unsigned MAX_ITER = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_radicand,
  output logic [WIDTH-1:0] div_num,
  output logic [WIDTH-1:0] div_den,
  input  logic [WIDTH-1:0] div_quo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_root,
  output logic [3:0]       out_iters,
  output logic             out_err
);

  // Start from a power of two at or above the largest possible root so the
  // iteration only ever descends.
  localparam int unsigned      X0Exp   = (WIDTH + 2) / 3;
  localparam logic [WIDTH-1:0] X0      = WIDTH'(1) << X0Exp;
  localparam logic [WIDTH-1:0] X0Sq    = X0 * X0;
  localparam int unsigned      CntW    = $clog2(DIV_LAT + 1) + 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(DIV_LAT);
  localparam logic [3:0]       IterMax = 4'(MAX_ITER);

  typedef enum logic [2:0] {StIdle, StDiv1, StDiv2, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, x_q, xn_q, root_q;
  logic [WIDTH-1:0] div_num_q, div_den_q;
  logic [3:0]       iters_q;
  logic             err_q;
  logic [CntW-1:0]  cnt_q;

  logic             cnt_last, xn_zero, xn_ge, iter_cap;
  logic [WIDTH-1:0] xn_sq, two_x_plus_q;

  assign cnt_last     = (cnt_q == CntLast);
  assign xn_zero      = (xn_q == '0);
  assign xn_ge        = (xn_q >= x_q);
  assign iter_cap     = (iters_q == IterMax);
  assign xn_sq        = xn_q * xn_q;
  assign two_x_plus_q = {x_q[WIDTH-2:0], 1'b0} + div_quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StDiv1;
      StDiv1:  if (cnt_last) state_d = StDiv2;
      StDiv2:  if (cnt_last) state_d = StCheck;
      StCheck: state_d = (xn_zero || xn_ge || iter_cap) ? StDone : StDiv1;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle:  in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q       <= '0;
      x_q       <= '0;
      xn_q      <= '0;
      root_q    <= '0;
      iters_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      div_num_q <= '0;
      div_den_q <= '0;
    end else begin
      if ((state_q == StDiv1) || (state_q == StDiv2)) begin
        cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end

      case (state_q)
        StIdle: begin
          if (in_valid) begin
            n_q       <= in_radicand;
            x_q       <= X0;
            iters_q   <= '0;
            err_q     <= 1'b0;
            div_num_q <= in_radicand;
            div_den_q <= X0Sq;
          end
        end
        StDiv1: begin
          // The quotient N/x^2 goes straight into the second division's numerator.
          if (cnt_last) begin
            div_num_q <= two_x_plus_q;
            div_den_q <= WIDTH'(3);
          end
        end
        StDiv2: begin
          if (cnt_last) begin
            xn_q    <= div_quo;
            iters_q <= iters_q + 4'd1;
          end
        end
        StCheck: begin
          if (xn_zero) begin
            root_q <= '0;
          end else if (xn_ge) begin
            root_q <= x_q;
          end else if (iter_cap) begin
            // On abort the freshest estimate is reported.
            root_q <= xn_q;
            err_q  <= 1'b1;
          end else begin
            x_q       <= xn_q;
            div_num_q <= n_q;
            div_den_q <= xn_sq;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_num   = div_num_q;
  assign div_den   = div_den_q;
  assign out_root  = root_q;
  assign out_iters = iters_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_cbrt_newton_seq.sv
// Directed bench for cbrt_newton_seq: three instances (default, DIV_LAT=3,
// MAX_ITER=2), each fed by its own behavioural pipelined divider.
module tb_cbrt_newton_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid    [3];
  logic         in_ready    [3];
  logic [W-1:0] in_radicand [3];
  logic [W-1:0] div_num     [3];
  logic [W-1:0] div_den     [3];
  logic [W-1:0] div_quo     [3];
  logic         out_valid   [3];
  logic         out_ready   [3];
  logic [W-1:0] out_root    [3];
  logic [3:0]   out_iters   [3];
  logic         out_err     [3];
  logic [W-1:0] lat3_pipe   [2];

  int n_vec = 0;
  int n_miss = 0;
  int zero_den = 0;
  logic [2*W-1:0] trace [$];

  cbrt_newton_seq #(.WIDTH(W), .DIV_LAT(1), .MAX_ITER(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_radicand(in_radicand[0]), .div_num(div_num[0]), .div_den(div_den[0]),
    .div_quo(div_quo[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_root(out_root[0]), .out_iters(out_iters[0]), .out_err(out_err[0])
  );

  cbrt_newton_seq #(.WIDTH(W), .DIV_LAT(3), .MAX_ITER(8)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_radicand(in_radicand[1]), .div_num(div_num[1]), .div_den(div_den[1]),
    .div_quo(div_quo[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_root(out_root[1]), .out_iters(out_iters[1]), .out_err(out_err[1])
  );

  cbrt_newton_seq #(.WIDTH(W), .DIV_LAT(1), .MAX_ITER(2)) u_dut_iter2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_radicand(in_radicand[2]), .div_num(div_num[2]), .div_den(div_den[2]),
    .div_quo(div_quo[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_root(out_root[2]), .out_iters(out_iters[2]), .out_err(out_err[2])
  );

  function automatic logic [W-1:0] quot(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  function automatic int ref_cbrt(input int n);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  always @(posedge clk) begin
    div_quo[0]   <= quot(div_num[0], div_den[0]);
    lat3_pipe[0] <= quot(div_num[1], div_den[1]);
    lat3_pipe[1] <= lat3_pipe[0];
    div_quo[1]   <= lat3_pipe[1];
    div_quo[2]   <= quot(div_num[2], div_den[2]);
  end

  // Busy-time divider monitor: zero denominators and the operand sequence of u_dut.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && !in_ready[i] && !out_valid[i] && div_den[i] == '0) zero_den++;
    end
    if (rst_n && !in_ready[0] && !out_valid[0] &&
        (trace.size() == 0 || trace[$] != {div_num[0], div_den[0]})) begin
      trace.push_back({div_num[0], div_den[0]});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int idx, input logic [W-1:0] n, input int hold, input bit noise,
                     output int root, output int iters, output int err, output int lat);
    int guard = 0;
    while (!in_ready[idx] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid[idx]    = 1'b1;
    in_radicand[idx] = n;
    @(negedge clk);
    in_valid[idx]    = noise;
    in_radicand[idx] = n ^ 8'h5a;
    lat = 0;
    while (!out_valid[idx] && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[idx]) check_eq("timeout", 32'(out_valid[idx]), 1);
    root  = int'(out_root[idx]);
    iters = int'(out_iters[idx]);
    err   = int'(out_err[idx]);
    check_eq("done_in_ready", 32'(in_ready[idx]), 0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check_eq("hold_stable", {out_valid[idx], out_err[idx], out_iters[idx], out_root[idx]},
               {1'b1, err[0], iters[3:0], root[W-1:0]});
    end
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    in_valid[idx]  = 1'b0;
    check_eq("post_in_ready", 32'(in_ready[idx]), 1);
    check_eq("post_out_valid", 32'(out_valid[idx]), 0);
  endtask

  typedef struct {
    int n;
    int root;
    int iters;
    int lat;
  } vec_t;

  vec_t dir_vecs [5] = '{
    '{27, 3, 3, 15}, '{64, 4, 3, 15}, '{63, 3, 4, 20}, '{1, 1, 5, 25}, '{0, 0, 5, 25}
  };

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t required below 900000", $time);
    $fatal(1);
  end

  initial begin
    int r, it, e, l;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]    = 1'b0;
      in_radicand[i] = '0;
      out_ready[i]   = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready[0]), 1);
    check_eq("rst_out_valid", 32'(out_valid[0]), 0);
    check_eq("rst_div_den", 32'(div_den[0]), 0);
    check_eq("rst_root", 32'(out_root[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    trace.delete();
    run(0, 8'd255, 0, 1'b0, r, it, e, l);
    check_eq("n255_root", r, 6);
    check_eq("n255_iters", it, 2);
    check_eq("n255_err", e, 0);
    check_eq("n255_lat", l, 10);
    check_eq("n255_ops", trace.size(), 4);
    check_eq("n255_op0", 32'(trace[0]), {8'd255, 8'd64});
    check_eq("n255_op1", 32'(trace[1]), {8'd19, 8'd3});
    check_eq("n255_op2", 32'(trace[2]), {8'd255, 8'd36});
    check_eq("n255_op3", 32'(trace[3]), {8'd19, 8'd3});

    foreach (dir_vecs[k]) begin
      run(0, 8'(dir_vecs[k].n), 0, 1'b0, r, it, e, l);
      check_eq("dir_root", r, dir_vecs[k].root);
      check_eq("dir_iters", it, dir_vecs[k].iters);
      check_eq("dir_err", e, 0);
      check_eq("dir_lat", l, dir_vecs[k].lat);
    end

    // Back-pressure plus stray in_valid while busy and while holding the result.
    run(0, 8'd64, 7, 1'b1, r, it, e, l);
    check_eq("bp_root", r, 4);
    check_eq("bp_iters", it, 3);
    run(0, 8'd27, 0, 1'b0, r, it, e, l);
    check_eq("after_bp_root", r, 3);

    // Reset asserted in the middle of the second division.
    in_valid[0]    = 1'b1;
    in_radicand[0] = 8'd255;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", 32'(in_ready[0]), 1);
    check_eq("mid_rst_out_valid", 32'(out_valid[0]), 0);
    check_eq("mid_rst_div_num", 32'(div_num[0]), 0);
    check_eq("mid_rst_div_den", 32'(div_den[0]), 0);
    check_eq("mid_rst_root", 32'(out_root[0]), 0);
    check_eq("mid_rst_iters", 32'(out_iters[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 8'd63, 0, 1'b0, r, it, e, l);
    check_eq("post_rst_root", r, 3);
    check_eq("post_rst_iters", it, 4);
    check_eq("post_rst_lat", l, 20);

    run(2, 8'd0, 0, 1'b0, r, it, e, l);
    check_eq("cap_err", e, 1);
    check_eq("cap_root", r, 3);
    check_eq("cap_iters", it, 2);
    check_eq("cap_lat", l, 10);

    for (int n = 0; n < 256; n++) begin
      run(0, 8'(n), 0, 1'b0, r, it, e, l);
      check_eq("sweep_lat1", r, ref_cbrt(n));
      run(1, 8'(n), 0, 1'b0, r, it, e, l);
      check_eq("sweep_lat3", r, ref_cbrt(n));
    end

    check_eq("den_zero_seen", zero_den, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
